// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port, fixed-latency word RAM
// between the pixel-read, weight-read and output-write clients.
// Commands are registered onto the memory port; read returns are routed
// back to the issuing client by a tag pipeline matching the RAM latency.
module ram_port_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  pix_req,
    input  logic [ADDR_W-1:0]     pix_addr,
    output logic                  pix_gnt,
    output logic                  pix_rvalid,
    output logic [DATA_W-1:0]     pix_rdata,

    input  logic                  wgt_req,
    input  logic [ADDR_W-1:0]     wgt_addr,
    output logic                  wgt_gnt,
    output logic                  wgt_rvalid,
    output logic [DATA_W-1:0]     wgt_rdata,

    input  logic                  out_req,
    input  logic [ADDR_W-1:0]     out_addr,
    input  logic [DATA_W-1:0]     out_wdata,
    input  logic [DATA_W/8-1:0]   out_wstrb,
    output logic                  out_gnt,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata
);

    // Client index: 0 pixel, 1 weights, 2 output write
    logic [1:0]            last;
    logic [2:0]            gnt;
    logic [1:0]            winner;
    logic                  mem_wgt;
    logic [RD_LATENCY-1:0] tag_v;
    logic [RD_LATENCY-1:0] tag_wgt;

    // Round-robin pick: search starts one past the last granted client
    always_comb begin
        gnt    = 3'b000;
        winner = 2'd0;
        case (last)
            2'd0: begin
                if (wgt_req)      begin gnt = 3'b010; winner = 2'd1; end
                else if (out_req) begin gnt = 3'b100; winner = 2'd2; end
                else if (pix_req) begin gnt = 3'b001; winner = 2'd0; end
            end
            2'd1: begin
                if (out_req)      begin gnt = 3'b100; winner = 2'd2; end
                else if (pix_req) begin gnt = 3'b001; winner = 2'd0; end
                else if (wgt_req) begin gnt = 3'b010; winner = 2'd1; end
            end
            default: begin
                if (pix_req)      begin gnt = 3'b001; winner = 2'd0; end
                else if (wgt_req) begin gnt = 3'b010; winner = 2'd1; end
                else if (out_req) begin gnt = 3'b100; winner = 2'd2; end
            end
        endcase
        // No client may see an accept while the block is held in reset
        if (rst) begin
            gnt = 3'b000;
        end
    end

    assign pix_gnt = gnt[0];
    assign wgt_gnt = gnt[1];
    assign out_gnt = gnt[2];

    // Register the winning command onto the memory port; idle cycles hold addr/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 2'd2;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wgt   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_en  <= |gnt;
            mem_we  <= gnt[2];
            mem_wgt <= gnt[1];
            if (|gnt) begin
                last <= winner;
                case (winner)
                    2'd0: begin
                        mem_addr  <= pix_addr;
                        mem_wstrb <= '0;
                    end
                    2'd1: begin
                        mem_addr  <= wgt_addr;
                        mem_wstrb <= '0;
                    end
                    default: begin
                        mem_addr  <= out_addr;
                        mem_wdata <= out_wdata;
                        mem_wstrb <= out_wstrb;
                    end
                endcase
            end
        end
    end

    // Tag pipeline: follows each issued read until its data leaves the RAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v   <= '0;
            tag_wgt <= '0;
        end else begin
            tag_v[0]   <= mem_en && !mem_we;
            tag_wgt[0] <= mem_wgt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_wgt[i] <= tag_wgt[i-1];
            end
        end
    end

    assign pix_rvalid = tag_v[RD_LATENCY-1] & ~tag_wgt[RD_LATENCY-1];
    assign wgt_rvalid = tag_v[RD_LATENCY-1] &  tag_wgt[RD_LATENCY-1];
    assign pix_rdata  = mem_rdata;
    assign wgt_rdata  = mem_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances (RAM latency 1 and 3) share
// one stimulus stream; a cycle-level model of the arbitration rules and a
// word memory predict grants, memory commands and read returns.
module tb_ram_port_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          pix_req = 1'b0, wgt_req = 1'b0, out_req = 1'b0;
    logic [AW-1:0] pix_addr = '0, wgt_addr = '0, out_addr = '0;
    logic [DW-1:0] out_wdata = '0;
    logic [SW-1:0] out_wstrb = '0;

    logic          pix_gnt1, wgt_gnt1, out_gnt1, pix_rv1, wgt_rv1, mem_en1, mem_we1;
    logic [DW-1:0] pix_rd1, wgt_rd1, mem_wdata1, mem_rdata1;
    logic [AW-1:0] mem_addr1;
    logic [SW-1:0] mem_wstrb1;

    logic          pix_gnt3, wgt_gnt3, out_gnt3, pix_rv3, wgt_rv3, mem_en3, mem_we3;
    logic [DW-1:0] pix_rd3, wgt_rd3, mem_wdata3, mem_rdata3;
    logic [AW-1:0] mem_addr3;
    logic [SW-1:0] mem_wstrb3;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .pix_req(pix_req), .pix_addr(pix_addr), .pix_gnt(pix_gnt1),
        .pix_rvalid(pix_rv1), .pix_rdata(pix_rd1),
        .wgt_req(wgt_req), .wgt_addr(wgt_addr), .wgt_gnt(wgt_gnt1),
        .wgt_rvalid(wgt_rv1), .wgt_rdata(wgt_rd1),
        .out_req(out_req), .out_addr(out_addr), .out_wdata(out_wdata),
        .out_wstrb(out_wstrb), .out_gnt(out_gnt1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_wstrb(mem_wstrb1), .mem_rdata(mem_rdata1)
    );

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .pix_req(pix_req), .pix_addr(pix_addr), .pix_gnt(pix_gnt3),
        .pix_rvalid(pix_rv3), .pix_rdata(pix_rd3),
        .wgt_req(wgt_req), .wgt_addr(wgt_addr), .wgt_gnt(wgt_gnt3),
        .wgt_rvalid(wgt_rv3), .wgt_rdata(wgt_rd3),
        .out_req(out_req), .out_addr(out_addr), .out_wdata(out_wdata),
        .out_wstrb(out_wstrb), .out_gnt(out_gnt3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_wstrb(mem_wstrb3), .mem_rdata(mem_rdata3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {4{32'hC0DE_0000 ^ {4'h0, a}}};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Backing RAMs seen by each DUT, with their own read latency
    logic [DW-1:0] dmem1 [logic [AW-1:0]];
    logic [DW-1:0] dmem3 [logic [AW-1:0]];
    logic [DW-1:0] rp1;
    logic [DW-1:0] rp3 [3];
    assign mem_rdata1 = rp1;
    assign mem_rdata3 = rp3[2];

    always @(posedge clk) begin
        logic [DW-1:0] w1, w3;
        w1 = {4{32'hDEAD_BEEF}};
        w3 = {4{32'hDEAD_BEEF}};
        if (mem_en1) begin
            w1 = dmem1.exists(mem_addr1) ? dmem1[mem_addr1] : init_word(mem_addr1);
            if (mem_we1) dmem1[mem_addr1] = merge(w1, mem_wdata1, mem_wstrb1);
        end
        if (mem_en3) begin
            w3 = dmem3.exists(mem_addr3) ? dmem3[mem_addr3] : init_word(mem_addr3);
            if (mem_we3) dmem3[mem_addr3] = merge(w3, mem_wdata3, mem_wstrb3);
        end
        rp1    <= w1;
        rp3[0] <= w3;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end

    // Reference model state: rotation pointer, expected port command,
    // client-view memory and scheduled read returns per latency
    int            m_last = 2;
    int            cyc = 0;
    logic          exp_en = 1'b0, exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [SW-1:0] exp_wstrb = '0;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    bit            s1_v [16], s1_c [16], s3_v [16], s3_c [16];
    logic [DW-1:0] s1_d [16], s3_d [16];
    logic [2:0]    took = 3'b000;

    // Compare process: every cycle, checked on the falling edge
    always @(negedge clk) begin
        int            w, slot;
        logic [2:0]    rq, eg;
        logic [DW-1:0] old;
        cyc++;
        slot = cyc % 16;
        rq = {out_req, wgt_req, pix_req};
        if (rst) begin
            chk("rst_gnt_l1", {out_gnt1, wgt_gnt1, pix_gnt1}, 0);
            chk("rst_gnt_l3", {out_gnt3, wgt_gnt3, pix_gnt3}, 0);
            chk("rst_mem_l1", {mem_en1, mem_we1, mem_addr1, mem_wstrb1}, 0);
            chk("rst_mem_l3", {mem_en3, mem_we3, mem_addr3, mem_wstrb3}, 0);
            chk("rst_wdata_l1", mem_wdata1, 0);
            chk("rst_rvalid", {pix_rv1, wgt_rv1, pix_rv3, wgt_rv3}, 0);
            m_last = 2;
            exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
            for (int i = 0; i < 16; i++) begin s1_v[i] = 0; s3_v[i] = 0; end
            took = 3'b000;
        end else begin
            w = -1;
            for (int k = 1; k <= 3; k++)
                if (w < 0 && rq[(m_last + k) % 3]) w = (m_last + k) % 3;
            eg = (w < 0) ? 3'b000 : 3'(1 << w);
            chk("gnt_l1", {out_gnt1, wgt_gnt1, pix_gnt1}, eg);
            chk("gnt_l3", {out_gnt3, wgt_gnt3, pix_gnt3}, eg);
            chk("mem_en_l1", mem_en1, exp_en);
            chk("mem_en_l3", mem_en3, exp_en);
            chk("mem_we_l1", mem_we1, exp_we);
            chk("mem_we_l3", mem_we3, exp_we);
            chk("mem_addr_l1", mem_addr1, exp_addr);
            chk("mem_addr_l3", mem_addr3, exp_addr);
            if (exp_en && exp_we) begin
                chk("mem_wdata_l1", mem_wdata1, exp_wdata);
                chk("mem_wdata_l3", mem_wdata3, exp_wdata);
            end
            if (exp_en) begin
                chk("mem_wstrb_l1", mem_wstrb1, exp_wstrb);
                chk("mem_wstrb_l3", mem_wstrb3, exp_wstrb);
            end
            chk("rvalid_l1", {wgt_rv1, pix_rv1}, {s1_v[slot] && s1_c[slot], s1_v[slot] && !s1_c[slot]});
            chk("rvalid_l3", {wgt_rv3, pix_rv3}, {s3_v[slot] && s3_c[slot], s3_v[slot] && !s3_c[slot]});
            if (s1_v[slot]) chk("rdata_l1", s1_c[slot] ? wgt_rd1 : pix_rd1, s1_d[slot]);
            if (s3_v[slot]) chk("rdata_l3", s3_c[slot] ? wgt_rd3 : pix_rd3, s3_d[slot]);
            s1_v[slot] = 0;
            s3_v[slot] = 0;
            took = eg;
            if (w >= 0) begin
                m_last = w;
                exp_en = 1;
                exp_we = (w == 2);
                exp_addr = (w == 0) ? pix_addr : (w == 1) ? wgt_addr : out_addr;
                old = ref_mem.exists(exp_addr) ? ref_mem[exp_addr] : init_word(exp_addr);
                if (w == 2) begin
                    exp_wdata = out_wdata;
                    exp_wstrb = out_wstrb;
                    ref_mem[exp_addr] = merge(old, out_wdata, out_wstrb);
                end else begin
                    exp_wstrb = '0;
                    s1_v[(cyc + 2) % 16] = 1; s1_c[(cyc + 2) % 16] = (w == 1); s1_d[(cyc + 2) % 16] = old;
                    s3_v[(cyc + 4) % 16] = 1; s3_c[(cyc + 4) % 16] = (w == 1); s3_d[(cyc + 4) % 16] = old;
                end
            end else begin
                exp_en = 0;
                exp_we = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random clients: hold a request until granted, occasionally abandon it
    task automatic rand_traffic(input int n, input int p_pix, input int p_wgt, input int p_out);
        repeat (n) begin
            step();
            if (took[0]) pix_req = 0;
            if (took[1]) wgt_req = 0;
            if (took[2]) out_req = 0;
            if (!pix_req && $urandom_range(99) < p_pix) begin
                pix_req = 1; pix_addr = AW'($urandom_range(31));
            end else if (pix_req && !took[0] && $urandom_range(99) < 3) pix_req = 0;
            if (!wgt_req && $urandom_range(99) < p_wgt) begin
                wgt_req = 1; wgt_addr = AW'($urandom_range(31));
            end else if (wgt_req && !took[1] && $urandom_range(99) < 3) wgt_req = 0;
            if (!out_req && $urandom_range(99) < p_out) begin
                out_req   = 1;
                out_addr  = AW'($urandom_range(31));
                out_wdata = {$urandom, $urandom, $urandom, $urandom};
                out_wstrb = SW'($urandom_range(65535));
            end
        end
        step();
        pix_req = 0; wgt_req = 0; out_req = 0;
    endtask

    initial begin
        int gi;
        // Reset held with every client requesting
        pix_req = 1; pix_addr = 28'h1;
        wgt_req = 1; wgt_addr = 28'h2;
        out_req = 1; out_addr = 28'h3; out_wdata = {4{32'h5555_AAAA}}; out_wstrb = 16'hF0F0;
        repeat (3) step();
        rst = 0;
        // Contention: rotation pix, wgt, out three times over
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            gi = pix_gnt1 ? 0 : wgt_gnt1 ? 1 : out_gnt1 ? 2 : 3;
            chk("rr_sequence", gi, i % 3);
        end
        step();
        pix_req = 0; wgt_req = 0; out_req = 0;
        repeat (6) step();

        // Single pixel read of word 0x10
        pix_req = 1; pix_addr = 28'h10;
        @(negedge clk); chk("sr_gnt", {wgt_gnt1, pix_gnt1}, 2'b01);
        step(); pix_req = 0;
        @(negedge clk); chk("sr_mem_cmd", {mem_en1, mem_we1, mem_addr1}, {2'b10, 28'h10});
        @(negedge clk);
        chk("sr_rvalid_l1", {wgt_rv1, pix_rv1}, 2'b01);
        chk("sr_rdata_l1", pix_rd1, 128'hC0DE0010_C0DE0010_C0DE0010_C0DE0010);
        @(negedge clk);
        @(negedge clk);
        chk("sr_rvalid_l3", {wgt_rv3, pix_rv3}, 2'b01);
        chk("sr_rdata_l3", pix_rd3, 128'hC0DE0010_C0DE0010_C0DE0010_C0DE0010);
        repeat (4) step();

        // Partial write to 0x20, then read it back
        out_req = 1; out_addr = 28'h20; out_wdata = {16{8'hAA}}; out_wstrb = 16'h000F;
        @(negedge clk); chk("ws_gnt", out_gnt1, 1);
        step(); out_req = 0; pix_req = 1; pix_addr = 28'h20;
        @(negedge clk);
        chk("ws_mem_cmd", {mem_en1, mem_we1, mem_wstrb1, mem_addr1}, {2'b11, 16'h000F, 28'h20});
        chk("ws_next_gnt", pix_gnt1, 1);
        step(); pix_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("ws_readback", pix_rd1, 128'hC0DE0020_C0DE0020_C0DE0020_AAAAAAAA);
        repeat (6) step();

        // Randomized traffic mixes
        rand_traffic(1500, 60, 60, 60);
        rand_traffic(300, 100, 100, 0);
        rand_traffic(100, 100, 0, 0);
        rand_traffic(300, 30, 0, 100);
        rand_traffic(500, 20, 20, 20);
        repeat (8) step();

        // Reset one cycle after a pixel grant: read dropped, pixel first again
        pix_req = 1; pix_addr = 28'h5;
        @(negedge clk); chk("mr_gnt", pix_gnt1, 1);
        step();
        rst = 1; pix_req = 1; pix_addr = 28'h6; wgt_req = 1; wgt_addr = 28'h7;
        step();
        step(); rst = 0;
        @(negedge clk);
        chk("mr_first_gnt", {wgt_gnt1, pix_gnt1}, 2'b01);
        chk("mr_no_rvalid_a", {pix_rv1, pix_rv3}, 2'b00);
        step(); pix_req = 0;
        @(negedge clk);
        chk("mr_second_gnt", {wgt_gnt1, pix_gnt1}, 2'b10);
        chk("mr_no_rvalid_b", {pix_rv1, pix_rv3}, 2'b00);
        step(); wgt_req = 0;
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one single-port, fixed-latency word RAM between the accelerator's three memory clients: pixel read, weights read and output write. It sits between the engine's RAM-style master ports and the backing RAM/DPI memory model. It registers the selected command onto the memory port and routes read data back to the issuing client using an in-flight tag pipeline.

## Interface
- ADDR_W, 28, word address width (byte address >> LSB)
- DATA_W, 128, data width; strobe width DATA_W/8
- RD_LATENCY, 1, cycles from mem_en (registered) to mem_rdata valid; ≥1
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pix_req  in  1  pixel read request; pix_addr  in  ADDR_W
- pix_gnt  out  1  pixel request accepted this cycle
- pix_rvalid  out  1  pixel read data valid; pix_rdata  out  DATA_W
- wgt_req / wgt_addr / wgt_gnt / wgt_rvalid / wgt_rdata: same as pixel, for weights
- out_req  in  1  output write request; out_addr  in  ADDR_W; out_wdata  in  DATA_W; out_wstrb  in  DATA_W/8
- out_gnt  out  1  write accepted this cycle
- mem_en  out  1  memory access; mem_we  out  1  write enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_wstrb  out  DATA_W/8
- mem_rdata  in  DATA_W  read data, RD_LATENCY cycles after mem_en

## Operation
- Client index: 0 pix, 1 wgt, 2 out. At most one grant per cycle.
- Round-robin: search starts at (last+1) mod 3; first client with req high wins. last updates only on a grant. Reset value last=2 (pixel has first priority).
- Grant is combinational from req and last; clients hold req and address/data stable until gnt is seen; req may drop without grant (no effect).
- Granted command is registered: mem_en=1, mem_we=(winner==2), mem_addr, mem_wdata, mem_wstrb (wstrb forced 0 for reads). No grant → mem_en=0, mem_we=0; addr/data hold last value.
- Tag pipeline, depth RD_LATENCY, shifted every cycle: entry = {valid, client}; inserted when mem_en && !mem_we. At pipeline output, valid drives pix_rvalid or wgt_rvalid for one cycle.
- pix_rdata and wgt_rdata = mem_rdata unconditionally; qualified only by rvalid.
- Writes produce no response; they are complete once mem_en&&mem_we is issued.
- No backpressure on read returns: clients must accept rvalid every cycle.

## Timing
- Reset (async assert, sync-release to clk): all gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, all rvalid=0, tag pipeline cleared, last=2.
- Grant cycle t → mem_en at t+1 → rvalid/rdata at t+1+RD_LATENCY. Read latency = 1+RD_LATENCY (2 at default).
- Throughput: one access per cycle; back-to-back grants to alternating clients with no bubble.
- Single requester continuously requesting: granted every cycle.
- All three requesting continuously: grants cycle pix, wgt, out, pix, ... ; each client ≤2 cycles between grants.
- Simultaneous read return and new grant: independent, both occur same cycle.
- Reset mid-operation: in-flight reads dropped (no rvalid after reset); pending un-granted requests re-arbitrated from last=2 after release.
- mem_rdata with no valid tag: ignored.

## Test plan
- Reset: hold rst with all req=1 → all gnt, mem_en, rvalid stay 0; release → first grant to pix.
- Single read: pix_req with addr 0x10 at cycle t → pix_gnt at t, mem_en=1/mem_we=0/mem_addr=0x10 at t+1, pix_rvalid=1 at t+2 with rdata equal to model word 0x10; wgt_rvalid stays 0.
- Contention: all three req held for 9 cycles, addrs 0x1/0x2/0x3 → grant sequence pix,wgt,out ×3; 3 writes with correct wstrb; pix/wgt rvalid 3 each with matching data.
- Write strobe: out_wdata=0xAA..AA, wstrb=0x000F at addr 0x20 → only bytes 0..3 of word 0x20 change; subsequent pix read of 0x20 returns updated bytes.
- RD_LATENCY=3: interleaved pix/wgt reads every cycle → rvalid order matches grant order, 4 cycles after each grant, no data swap.
- Reset mid-flight: assert rst one cycle after pix_gnt → no pix_rvalid after release; next grant is pix.
